// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: instruction/address widths, NOP/HLT encodings,
// and the fetch-stage state enum.
package cpu_pkg;

  localparam int unsigned IW = 17;
  localparam int unsigned AW = 16;

  typedef logic [IW-1:0] instr_t;

  localparam instr_t     NOP_INSTR = 17'h0F000;
  localparam logic [4:0] HLT_OP    = 5'h1F;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > hold > squash (NOP, vld=0) > load.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned    IW        = cpu_pkg::IW,
  parameter int unsigned    AW        = cpu_pkg::AW,
  parameter logic [IW-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          squash,
  input  logic [IW-1:0] ld_instr,
  input  logic [AW-1:0] ld_pc,
  output logic [IW-1:0] instr_q,
  output logic [AW-1:0] pc_q,
  output logic          vld_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      vld_q   <= 1'b0;
    end else if (hold) begin
      instr_q <= instr_q;
      pc_q    <= pc_q;
      vld_q   <= vld_q;
    end else if (squash) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      instr_q <= ld_instr;
      pc_q    <= ld_pc;
      vld_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives IM address/read enable, fills IF/ID.
// Optional HLT detection enabled by defining INSTR_FETCH_HLT_DETECT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned    IW        = cpu_pkg::IW,
  parameter int unsigned    AW        = cpu_pkg::AW,
  parameter logic [IW-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_IF,
  input  logic          flow_change_EX,
  input  logic [AW-1:0] dst_EX,
  input  logic [IW-1:0] instr,
  output logic [AW-1:0] addr,
  output logic          rd_en,
  output logic [IW-1:0] instr_IF_ID,
  output logic [AW-1:0] pc_IF_ID,
  output logic          vld_IF_ID,
  output logic          halted
);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic          fetch_run;
  logic          capture;

  assign pc_inc  = pc + AW'(1);
  assign capture = ~flow_change_EX & ~stall_IF & fetch_run;

`ifdef INSTR_FETCH_HLT_DETECT_EN
  fetch_state_t state_q;
  fetch_state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FS_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flow_change_EX)
      state_d = FS_RUN;
    else if (capture && (instr[IW-1 -: 5] == HLT_OP))
      state_d = FS_HALT;
  end

  always_comb begin
    fetch_run = (state_q == FS_RUN);
    halted    = (state_q == FS_HALT);
  end
`else
  always_comb begin
    fetch_run = 1'b1;
    halted    = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)                 pc <= '0;
    else if (flow_change_EX) pc <= dst_EX;
    else if (capture)        pc <= pc_inc;
  end

  assign addr  = pc;
  assign rd_en = ~rst & fetch_run & (~stall_IF | flow_change_EX);

  // A redirect beats a stall, so hold is masked by flow_change_EX; HALT squashes.
  if_id_reg #(
    .IW        (IW),
    .AW        (AW),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .hold     (stall_IF & ~flow_change_EX),
    .squash   (flow_change_EX | ~fetch_run),
    .ld_instr (instr),
    .ld_pc    (pc_inc),
    .instr_q  (instr_IF_ID),
    .pc_q     (pc_IF_ID),
    .vld_q    (vld_IF_ID)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: IM model, reference model, directed + random stimulus.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_IF = 1'b0;
  logic        flow_change_EX = 1'b0;
  logic [15:0] dst_EX = '0;
  logic [16:0] instr = '0;
  logic [15:0] addr;
  logic        rd_en;
  logic [16:0] instr_IF_ID;
  logic [15:0] pc_IF_ID;
  logic        vld_IF_ID;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_IF       (stall_IF),
    .flow_change_EX (flow_change_EX),
    .dst_EX         (dst_EX),
    .instr          (instr),
    .addr           (addr),
    .rd_en          (rd_en),
    .instr_IF_ID    (instr_IF_ID),
    .pc_IF_ID       (pc_IF_ID),
    .vld_IF_ID      (vld_IF_ID),
    .halted         (halted)
  );

  logic [16:0] mem [0:65535];

  // Instruction memory: synchronous read on the falling edge, output holds when rd_en=0.
  always @(negedge clk) if (rd_en) instr <= mem[addr];

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [16:0] ins;
    logic [15:0] pc;
    logic        vld;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int done_items = 0;

`ifdef INSTR_FETCH_HLT_DETECT_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  // Reference model: architectural PC, IM output, IF/ID contents, halted flag.
  logic [15:0] pc_m = '0;
  logic [16:0] im_m = '0;
  logic [16:0] ins_m = 17'h0F000;
  logic [15:0] pcid_m = '0;
  logic        vld_m = 1'b0;
  logic        halt_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [15:0] d);
    exp_t e;
    @(posedge clk); #1;
    rst = r; stall_IF = s; flow_change_EX = f; dst_EX = d;
    e.rd   = !r && !halt_m && (!s || f);
    e.addr = pc_m;
    if (e.rd) im_m = mem[pc_m];
    if (r) begin
      pc_m = 0; ins_m = NOP_INSTR; pcid_m = 0; vld_m = 0; halt_m = 0;
    end else if (f) begin
      pc_m = d; ins_m = NOP_INSTR; pcid_m = 0; vld_m = 0; halt_m = 0;
    end else if (s) begin
      // everything holds
    end else if (halt_m) begin
      ins_m = NOP_INSTR; pcid_m = 0; vld_m = 0;
    end else begin
      ins_m = im_m; pcid_m = pc_m + 16'd1; vld_m = 1; pc_m = pc_m + 16'd1;
      if (HLT_EN && im_m[16:12] == 5'h1F) halt_m = 1;
    end
    e.ins = ins_m; e.pc = pcid_m; e.vld = vld_m; e.hlt = halt_m;
    q.push_back(e);
    pushed++;
  endtask

  // Monitor: pre-edge outputs at negedge, registered outputs just after the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_en", 32'(rd_en), 32'(e.rd));
        chk("addr", 32'(addr), 32'(e.addr));
        @(posedge clk); #2;
        chk("instr_IF_ID", 32'(instr_IF_ID), 32'(e.ins));
        chk("pc_IF_ID", 32'(pc_IF_ID), 32'(e.pc));
        chk("vld_IF_ID", 32'(vld_IF_ID), 32'(e.vld));
        chk("halted", 32'(halted), 32'(e.hlt));
        done_items++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [16:0] w;
    int unsigned wait_cycles;
    for (int unsigned i = 0; i < 65536; i++) begin
      v = $urandom;
      w = v[16:0];
      if (w[16:12] == 5'h1F) w[16] = 1'b0;
      mem[i] = w;
    end
    for (int unsigned i = 0; i < 8; i++) mem[i] = 17'(i + 1);
    mem[5] = 17'h1F000;

    // Reset, sequential fetch, stall, redirect+stall, wrap, halt program.
    step(1, 0, 0, 16'h0000);
    step(1, 1, 0, 16'h1234);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(0, 1, 1, 16'h0100);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h0000);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      logic r, s, f;
      logic [15:0] d;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 10);
      d = ($urandom_range(0, 3) == 0) ? 16'(3 + $urandom_range(0, 3))
                                      : 16'($urandom_range(0, 2047));
      step(r, s, f, d);
    end
    step(0, 0, 0, 16'h0000);

    wait_cycles = 0;
    while (done_items != pushed && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #5;
    if (done_items != pushed) begin
      failures++;
      $display("FAIL drain actual=%0d required=%0d", done_items, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
